// File: rtl/interleaver_out_packer_pkg.sv
// rtl/interleaver_out_packer_pkg.sv - shared constants and FSM encoding for the interleaver output packer
package interleaver_out_packer_pkg;

  localparam int BITCNT_W   = 13;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = 2;
  localparam int FIFO_W     = 9;

  localparam logic [BITCNT_W-1:0] K_SMALL = 13'd1056;
  localparam logic [BITCNT_W-1:0] K_LARGE = 13'd6144;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/interleaver_out_packer_fifo.sv
// rtl/interleaver_out_packer_fifo.sv - 4-entry {last, byte} FIFO between the packer and the consumer
module ilv_byte_fifo
  import interleaver_out_packer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [FIFO_W-1:0] push_data,
  input  logic              pop,
  output logic [FIFO_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  logic [FIFO_W-1:0]     mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic [FIFO_PTR_W:0]   count;
  logic                  do_pop;
  logic                  do_push;

  assign full    = (count == (FIFO_PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (FIFO_PTR_W+1)'(do_push) - (FIFO_PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/interleaver_out_packer.sv
// rtl/interleaver_out_packer.sv - packs the interleaver bit stream into bytes and frames the block
module interleaver_out_packer
  import interleaver_out_packer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       il_ready,
  input  logic       il_bit,
  input  logic       il_done,
  input  logic       block_size,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       block_done,
  output logic       overflow,
  output logic       short_block
);

  state_t                state;
  state_t                state_next;
  logic [BITCNT_W-1:0]   bit_cnt;
  logic [BITCNT_W-1:0]   cnt_next;
  logic [BITCNT_W-1:0]   limit;
  logic [7:0]            byte_reg;
  logic [7:0]            byte_next;
  logic [7:0]            byte_keep;
  logic                  size_lat;
  logic                  size_sel;
  logic                  take;
  logic                  push;
  logic                  push_last;
  logic                  short_hit;
  logic                  pop;
  logic                  drop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_W-1:0]     head;

  // The first bit of a block sees block_size directly; later bits use the latched copy.
  assign size_sel = (state == ST_IDLE) ? block_size : size_lat;
  assign limit    = size_sel ? K_LARGE : K_SMALL;
  assign take     = il_ready && ((state == ST_IDLE) || (state == ST_COLLECT));
  assign pop      = out_valid && out_ready;
  assign drop     = push && fifo_full && !pop;

  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    byte_next  = byte_reg;
    byte_keep  = byte_reg;
    push       = 1'b0;
    push_last  = 1'b0;
    short_hit  = 1'b0;
    case (state)
      ST_IDLE, ST_COLLECT: begin
        if (take) begin
          byte_next[bit_cnt[2:0]] = il_bit;
          cnt_next                = bit_cnt + BITCNT_W'(1);
          state_next              = ST_COLLECT;
        end
        if (take && (cnt_next == limit)) begin
          push       = 1'b1;
          push_last  = 1'b1;
          state_next = ST_FLUSH;
        end else if ((state == ST_COLLECT) && il_done) begin
          // Early end: whatever is assembled goes out zero-padded and closes the block.
          short_hit  = 1'b1;
          push       = 1'b1;
          push_last  = 1'b1;
          state_next = ST_FLUSH;
        end else if (take && (bit_cnt[2:0] == 3'd7)) begin
          push = 1'b1;
        end
        byte_keep = push ? 8'h00 : byte_next;
      end
      ST_FLUSH: begin
        // Falling back on empty keeps a dropped last byte from stalling the FSM.
        if ((pop && head[8]) || fifo_empty) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        byte_keep  = 8'h00;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      byte_reg    <= '0;
      size_lat    <= 1'b0;
      overflow    <= 1'b0;
      short_block <= 1'b0;
    end else begin
      state    <= state_next;
      bit_cnt  <= cnt_next;
      byte_reg <= byte_keep;
      if ((state == ST_IDLE) && take) begin
        size_lat <= block_size;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (short_hit) begin
        short_block <= 1'b1;
      end
    end
  end

  ilv_byte_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({push_last, byte_next}),
    .pop       (pop),
    .rd_data   (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign out_data   = head[7:0];
  assign out_last   = head[8];
  assign block_done = (state == ST_DONE);

endmodule
